vram_sched: RTL and testbench

Single-port video-memory scheduler sitting between the VGA scan-out path and a pixel-write requester (drawing engine / keyboard-driven editor). It issues one read per displayed pixel using the `{h_addr, v_addr[8:0]}` address map, and grants every remaining memory cycle to a one-entry buffered write port. It also expands the 12-bit stored colour to the 24-bit `vga_ctrl` data word. Reads are never dropped; writes yield.

---
 rtl/vram_pkg.sv | 31 +++
 rtl/vram_wr_buf.sv | 38 +++
 rtl/vram_sched.sv | 125 ++++++++++++
 tb/tb_vram_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: widths, memory-port states and pixel helpers for vram_sched.
// Build option VRAM_SCHED_BLANK_WR_EN is consumed by vram_sched.
package vram_pkg;

   localparam int ADDR_W  = 19;
   localparam int DATA_W  = 12;
   localparam int H_W     = 10;
   localparam int V_W     = 10;
   localparam int COLOR_W = 24;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } port_state_t;

   // Column in the high bits, 9 row bits below.
   function automatic logic [ADDR_W-1:0] pix_addr(
      input logic [H_W-1:0] h,
      input logic [8:0]     v
   );
      return {h, v};
   endfunction

   function automatic logic [COLOR_W-1:0] expand(
      input logic [DATA_W-1:0] c
   );
      return {c[11:8], 4'h0, c[7:4], 4'h0, c[3:0], 4'h0};
   endfunction

endpackage

// File: rtl/vram_wr_buf.sv
// vram_wr_buf: one-entry pixel-write buffer with req/ack handshake.
// The entry is released in the cycle the scheduler issues it.
module vram_wr_buf
   import vram_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              issue,
   output logic              wr_ack,
   output logic              accept,
   output logic              buf_full,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [DATA_W-1:0] buf_data
);

   // The ack cycle still sees wr_req high, so it must not re-accept.
   assign accept = wr_req && !buf_full && !wr_ack;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ack   <= 1'b0;
         buf_full <= 1'b0;
         buf_addr <= '0;
         buf_data <= '0;
      end else begin
         wr_ack   <= accept;
         buf_full <= (buf_full || accept) && !issue;
         if (accept) begin
            buf_addr <= wr_addr;
            buf_data <= wr_data;
         end
      end
   end

endmodule

// File: rtl/vram_sched.sv
// vram_sched: single-port VRAM arbiter, scan-out reads beat buffered writes.
// Define VRAM_SCHED_BLANK_WR_EN to issue writes only outside active video.
module vram_sched
   import vram_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_en,
   input  logic [H_W-1:0]     h_addr,
   input  logic [V_W-1:0]     v_addr,
   input  logic               valid,
   input  logic               wr_req,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0]  wr_data,
   output logic               wr_ack,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_we,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic [COLOR_W-1:0] pix_color,
   output logic               pix_valid
);

   port_state_t state, state_n;

   logic              buf_full;
   logic              accept;
   logic              wr_pend;
   logic              wr_ok;
   logic              issue;
   logic [ADDR_W-1:0] buf_addr;
   logic [DATA_W-1:0] buf_data;
   logic [ADDR_W-1:0] src_addr;
   logic [DATA_W-1:0] src_data;
   logic              p1_en;
   logic              p2_en;
   logic              p2_act;
   logic              unused_v9;

   assign unused_v9 = v_addr[9];

   vram_wr_buf u_wr_buf (
      .clk      (clk),
      .reset    (reset),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .issue    (issue),
      .wr_ack   (wr_ack),
      .accept   (accept),
      .buf_full (buf_full),
      .buf_addr (buf_addr),
      .buf_data (buf_data)
   );

   // A request accepted this cycle can go straight to memory next cycle.
   assign wr_pend  = buf_full || accept;
   assign src_addr = buf_full ? buf_addr : wr_addr;
   assign src_data = buf_full ? buf_data : wr_data;

`ifdef VRAM_SCHED_BLANK_WR_EN
   assign wr_ok = !valid;
`else
   assign wr_ok = 1'b1;
`endif

   always_comb begin
      state_n = S_IDLE;
      if (pix_en && valid) begin
         state_n = S_READ;
      end else if (wr_pend && wr_ok) begin
         state_n = S_WRITE;
      end
   end

   assign issue  = (state_n == S_WRITE);
   assign mem_we = (state == S_WRITE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         unique case (state_n)
            S_READ: begin
               mem_addr <= pix_addr(h_addr, v_addr[8:0]);
            end
            S_WRITE: begin
               mem_addr  <= src_addr;
               mem_wdata <= src_data;
            end
            default: begin
            end
         endcase
      end
   end

   // Strobe pipeline: every pix_en refreshes the pixel three cycles later.
   always_ff @(posedge clk) begin
      if (reset) begin
         p1_en     <= 1'b0;
         p2_en     <= 1'b0;
         p2_act    <= 1'b0;
         pix_color <= '0;
         pix_valid <= 1'b0;
      end else begin
         p1_en  <= pix_en;
         p2_en  <= p1_en;
         p2_act <= (state == S_READ);
         if (p2_en) begin
            pix_valid <= p2_act;
            pix_color <= p2_act ? expand(mem_rdata) : '0;
         end
      end
   end

endmodule

// File: tb/tb_vram_sched.sv
// tb_vram_sched: directed vectors plus randomized traffic against
// a queue-based scheduling model for vram_sched.
module tb_vram_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_en;
   logic [9:0]  h_addr;
   logic [9:0]  v_addr;
   logic        valid;
   logic        wr_req;
   logic [18:0] wr_addr;
   logic [11:0] wr_data;
   logic        wr_ack;
   logic [18:0] mem_addr;
   logic        mem_we;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;
   logic [23:0] pix_color;
   logic        pix_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vram_sched dut (
      .clk       (clk),
      .reset     (reset),
      .pix_en    (pix_en),
      .h_addr    (h_addr),
      .v_addr    (v_addr),
      .valid     (valid),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .pix_color (pix_color),
      .pix_valid (pix_valid)
   );

   // Memory behind the port: synchronous read, one-cycle latency.
   logic [11:0] mem [logic [18:0]];
   always @(posedge clk) begin
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 12'h0;
      if (mem_we) mem[mem_addr] = mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      logic        act;
      logic [23:0] color;
   } pix_t;
   typedef struct {
      logic [18:0] a;
      logic [11:0] d;
   } wr_t;

   logic [11:0] ref_mem [logic [18:0]];
   pix_t        pq[$];
   wr_t         wq[$];
   int          cyc = 0;
   bit          have_exp = 0;
   logic        e_ack, e_we, e_pv;
   logic [18:0] e_addr;
   logic [11:0] e_wdata;
   logic [23:0] e_pc;

   function automatic logic [18:0] map_addr(input int h, input int v);
      return 19'(h * 512 + (v % 512));
   endfunction

   function automatic logic [23:0] widen(input logic [11:0] c);
      int r;
      r = (int'(c[11:8]) << 20) + (int'(c[7:4]) << 12) + (int'(c[3:0]) << 4);
      return 24'(r);
   endfunction

   function automatic logic wr_allowed(input logic vld);
`ifdef VRAM_SCHED_BLANK_WR_EN
      return !vld;
`else
      return 1'b1 | vld;
`endif
   endfunction

   always @(negedge clk) begin
      logic  acc;
      logic [18:0] ra;
      pix_t  p;
      wr_t   w;
      if (have_exp) begin
         check("m_wr_ack", wr_ack, e_ack);
         check("m_mem_we", mem_we, e_we);
         check("m_mem_addr", mem_addr, e_addr);
         if (e_we) check("m_mem_wdata", mem_wdata, e_wdata);
         check("m_pix_color", pix_color, e_pc);
         check("m_pix_valid", pix_valid, e_pv);
      end
      have_exp = 1;
      if (reset) begin
         wq.delete();
         pq.delete();
         e_ack = 0; e_we = 0; e_addr = 0;
         e_wdata = 0; e_pc = 0; e_pv = 0;
      end else begin
         acc = wr_req && wq.size() == 0 && !e_ack;
         if (acc) begin
            w.a = wr_addr; w.d = wr_data;
            wq.push_back(w);
         end
         e_ack = acc;
         e_we = 0;
         if (pix_en) begin
            ra = map_addr(int'(h_addr), int'(v_addr));
            p.due = cyc + 3;
            p.act = valid;
            p.color = 0;
            if (valid && ref_mem.exists(ra)) p.color = widen(ref_mem[ra]);
            pq.push_back(p);
         end
         if (pix_en && valid) begin
            e_addr = map_addr(int'(h_addr), int'(v_addr));
         end else if (wq.size() > 0 && wr_allowed(valid)) begin
            w = wq.pop_front();
            e_we = 1; e_addr = w.a; e_wdata = w.d;
            ref_mem[w.a] = w.d;
         end
         if (pq.size() > 0 && pq[0].due == cyc + 1) begin
            e_pc = pq[0].color;
            e_pv = pq[0].act;
            void'(pq.pop_front());
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (wr_ack) wr_req = 0;
   endtask

   task automatic preload(input logic [18:0] a, input logic [11:0] d);
      mem[a] = d;
      ref_mem[a] = d;
   endtask

   typedef struct {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        vld;
      logic [11:0] mval;
      logic [18:0] e_addr;
      logic [23:0] e_color;
      logic        e_valid;
   } vec_t;

   vec_t vecs[6];
   bit   alt;

   initial begin
      vecs[0] = '{10'd5,   10'd3,   1'b1, 12'hABC, 19'h00A03, 24'hA0B0C0, 1'b1};
      vecs[1] = '{10'd0,   10'd0,   1'b1, 12'h000, 19'h00000, 24'h000000, 1'b1};
      vecs[2] = '{10'd1023,10'd511, 1'b1, 12'hFFF, 19'h7FFFF, 24'hF0F0F0, 1'b1};
      vecs[3] = '{10'd7,   10'd9,   1'b0, 12'h777, 19'h00000, 24'h000000, 1'b0};
      vecs[4] = '{10'd12,  10'd515, 1'b1, 12'h123, 19'h01803, 24'h102030, 1'b1};
      vecs[5] = '{10'd639, 10'd479, 1'b1, 12'h5A7, 19'h4FFDF, 24'h50A070, 1'b1};

      reset = 1; pix_en = 0; h_addr = 0; v_addr = 0; valid = 0;
      wr_req = 0; wr_addr = 0; wr_data = 0;
      repeat (3) @(posedge clk);
      #1;
      reset = 0;

      // idle after reset
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_we", mem_we, 1'b0);
      end
      check("rst_ack", wr_ack, 1'b0);
      check("rst_addr", mem_addr, 19'h0);
      check("rst_wdata", mem_wdata, 12'h0);
      check("rst_color", pix_color, 24'h0);
      check("rst_pvalid", pix_valid, 1'b0);

      // table-driven scan-out reads
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].vld) preload(vecs[i].e_addr, vecs[i].mval);
         pix_en = 1; h_addr = vecs[i].h; v_addr = vecs[i].v;
         valid = vecs[i].vld;
         tick();
         pix_en = 0;
         check("rd_we", mem_we, 1'b0);
         if (vecs[i].vld) check("rd_addr", mem_addr, vecs[i].e_addr);
         tick();
         tick();
         check("rd_color", pix_color, vecs[i].e_color);
         check("rd_pvalid", pix_valid, vecs[i].e_valid);
         tick();
      end

      // single write with a free port, then read it back
      valid = 0;
      wr_req = 1; wr_addr = 19'h12345; wr_data = 12'hF00;
      tick();
      check("wr_ack", wr_ack, 1'b1);
      check("wr_we", mem_we, 1'b1);
      check("wr_addr", mem_addr, 19'h12345);
      check("wr_data", mem_wdata, 12'hF00);
      tick();
      check("wr_we_once", mem_we, 1'b0);
      pix_en = 1; h_addr = 10'd145; v_addr = 10'd325; valid = 1;
      tick();
      pix_en = 0; valid = 0;
      check("rb_addr", mem_addr, 19'h12345);
      tick();
      tick();
      check("rb_color", pix_color, 24'hF00000);

      // write deferred by a read, second request held off
      tick();
      preload(19'h02807, 12'h321);
      wr_req = 1; wr_addr = 19'h00111; wr_data = 12'h0AA;
      pix_en = 1; h_addr = 10'd20; v_addr = 10'd7; valid = 1;
      tick();
      check("ct_ack1", wr_ack, 1'b1);
      check("ct_rd_we", mem_we, 1'b0);
      check("ct_rd_addr", mem_addr, 19'h02807);
      pix_en = 0; valid = 0;
      wr_req = 1; wr_addr = 19'h00222; wr_data = 12'h0BB;
      tick();
      check("ct_wr1_we", mem_we, 1'b1);
      check("ct_wr1_addr", mem_addr, 19'h00111);
      check("ct_wr1_data", mem_wdata, 12'h0AA);
      check("ct_no_ack2", wr_ack, 1'b0);
      pix_en = 1; valid = 1;
      tick();
      check("ct_ack2", wr_ack, 1'b1);
      check("ct_rd2_we", mem_we, 1'b0);
      pix_en = 0; valid = 0;
      tick();
      check("ct_wr2_we", mem_we, 1'b1);
      check("ct_wr2_addr", mem_addr, 19'h00222);
      check("ct_wr2_data", mem_wdata, 12'h0BB);
      tick();
      check("ct_wr2_once", mem_we, 1'b0);
      check("ct_color", pix_color, 24'h302010);

`ifdef VRAM_SCHED_BLANK_WR_EN
      // active video blocks the write until blanking
      valid = 1;
      wr_req = 1; wr_addr = 19'h00444; wr_data = 12'h444;
      tick();
      check("bl_ack", wr_ack, 1'b1);
      for (int i = 0; i < 6; i++) begin
         check("bl_hold_we", mem_we, 1'b0);
         tick();
      end
      check("bl_hold_we", mem_we, 1'b0);
      valid = 0;
      tick();
      check("bl_we", mem_we, 1'b1);
      check("bl_addr", mem_addr, 19'h00444);
      tick();
`endif

      // reset between ack and issue drops the write
      wr_req = 1; wr_addr = 19'h00333; wr_data = 12'hCCC;
      pix_en = 1; h_addr = 10'd20; v_addr = 10'd7; valid = 1;
      tick();
      check("rs_ack", wr_ack, 1'b1);
      check("rs_we", mem_we, 1'b0);
      reset = 1; pix_en = 0; valid = 0;
      tick();
      reset = 0;
      check("rs_ack0", wr_ack, 1'b0);
      check("rs_we0", mem_we, 1'b0);
      check("rs_addr0", mem_addr, 19'h0);
      check("rs_wdata0", mem_wdata, 12'h0);
      check("rs_color0", pix_color, 24'h0);
      check("rs_pvalid0", pix_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rs_no_we", mem_we, 1'b0);
         check("rs_no_pix", pix_valid, 1'b0);
      end
      check("rs_lost", 32'(mem.exists(19'h00333)), 32'd0);

      // randomized traffic, checked by the model every cycle
      alt = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) alt = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 399) == 0);
         if (alt) pix_en = (c % 2 == 0);
         else     pix_en = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) valid = !valid;
         h_addr = 10'($urandom_range(0, 3));
         v_addr = 10'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) v_addr = v_addr | 10'h200;
         if (!wr_req && $urandom_range(0, 2) == 0) begin
            wr_req  = 1;
            wr_addr = 19'($urandom_range(0, 3) * 512 + $urandom_range(0, 3));
            wr_data = 12'($urandom);
         end
         tick();
      end
      reset = 0; pix_en = 0; valid = 0;
      repeat (8) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
